// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, requests words from instruction memory and fills
// the IF/ID register, with a one-entry buffer so a word returned during a stall is kept.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        shouldStall,
    input  logic        shouldJumpOrBranch,
    input  logic [31:0] jumpOrBranchPc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc_4,
    output logic        id_valid,
    output logic [31:0] debug_pc
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetchState_t;

    fetchState_t state;
    logic [31:0] pc;
    logic [31:0] holdWord;
    logic [31:0] pcPlus4;
    logic [31:0] alignedTarget;
    logic        takeRedirect;

    assign pcPlus4       = pc + 32'd4;
    assign alignedTarget = {jumpOrBranchPc[31:2], 2'b00};
    // A stalled decode cannot accept a redirect; it re-asserts it once the stall clears.
    assign takeRedirect  = shouldJumpOrBranch && !shouldStall;

    // Gated by rst so no request leaves the stage while reset is held.
    assign imem_req  = rst && (state == FETCH);
    assign imem_addr = pc;
    assign debug_pc  = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            holdWord    <= '0;
            instruction <= NOP_WORD;
            pc_4        <= '0;
            id_valid    <= 1'b0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (takeRedirect) begin
                        pc          <= alignedTarget;
                        instruction <= NOP_WORD;
                        id_valid    <= 1'b0;
                    end else if (shouldStall) begin
                        if (imem_ready) begin
                            holdWord <= imem_rdata;
                            state    <= HOLD;
                        end
                    end else if (imem_ready) begin
                        instruction <= imem_rdata;
                        pc_4        <= pcPlus4;
                        id_valid    <= 1'b1;
                        pc          <= pcPlus4;
                    end else begin
                        instruction <= NOP_WORD;
                        id_valid    <= 1'b0;
                    end
                end
                HOLD: begin
                    if (takeRedirect) begin
                        pc          <= alignedTarget;
                        instruction <= NOP_WORD;
                        id_valid    <= 1'b0;
                        state       <= FETCH;
                    end else if (!shouldStall) begin
                        instruction <= holdWord;
                        pc_4        <= pcPlus4;
                        id_valid    <= 1'b1;
                        pc          <= pcPlus4;
                        state       <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand-written corner sequences, then random
// stimulus against a word-availability reference model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        shouldStall = 1'b0;
    logic        shouldJumpOrBranch = 1'b0;
    logic [31:0] jumpOrBranchPc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc_4;
    logic        id_valid;
    logic [31:0] debug_pc;
    logic [31:0] junkWord = 32'hDEAD_BEEF;

    int unsigned checks = 0;
    int unsigned failures = 0;

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_WORD(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .shouldStall(shouldStall), .shouldJumpOrBranch(shouldJumpOrBranch),
        .jumpOrBranchPc(jumpOrBranchPc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instruction(instruction), .pc_4(pc_4), .id_valid(id_valid), .debug_pc(debug_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] wordAt(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory returns junk whenever it is not ready, so a bubble that latches rdata shows up.
    always_comb imem_rdata = imem_ready ? wordAt(imem_addr) : junkWord;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkAll(input string tag, input logic [31:0] eInstr, input logic [31:0] ePc4,
                          input logic eValid, input logic [31:0] ePc, input logic eReq);
        chk({tag, ".instruction"}, instruction, eInstr);
        chk({tag, ".pc_4"}, pc_4, ePc4);
        chk({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, eValid});
        chk({tag, ".debug_pc"}, debug_pc, ePc);
        chk({tag, ".imem_addr"}, imem_addr, ePc);
        chk({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, eReq});
    endtask

    task automatic drive(input logic st, input logic jb, input logic [31:0] tgt, input logic rdy);
        shouldStall = st;
        shouldJumpOrBranch = jb;
        jumpOrBranchPc = tgt;
        imem_ready = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic        stall;
        logic        jb;
        logic [31:0] target;
        logic        ready;
        logic [31:0] expInstr;
        logic [31:0] expPc4;
        logic        expValid;
        logic [31:0] expPc;
        logic        expReq;
    } vec_t;

    vec_t vecs [19];

    // Reference model: PC, whether a returned word is parked, and the IF/ID contents.
    logic [31:0] mPc, mInstr, mPc4;
    logic        mValid, mHeld;

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 32'h0, 1'b1, wordAt(32'h00), 32'h04, 1'b1, 32'h04, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 32'h0, 1'b1, wordAt(32'h04), 32'h08, 1'b1, 32'h08, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 32'h0, 1'b1, wordAt(32'h08), 32'h0C, 1'b1, 32'h0C, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 32'h0, 1'b1, wordAt(32'h0C), 32'h10, 1'b1, 32'h10, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 32'h0, 1'b1, wordAt(32'h0C), 32'h10, 1'b1, 32'h10, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0, 1'b1, wordAt(32'h0C), 32'h10, 1'b1, 32'h10, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0, 1'b1, wordAt(32'h0C), 32'h10, 1'b1, 32'h10, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 32'h0, 1'b1, wordAt(32'h10), 32'h14, 1'b1, 32'h14, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 32'h0, 1'b1, wordAt(32'h14), 32'h18, 1'b1, 32'h18, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 32'h0, 1'b1, wordAt(32'h18), 32'h1C, 1'b1, 32'h1C, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 32'h0, 1'b1, wordAt(32'h1C), 32'h20, 1'b1, 32'h20, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 32'h103, 1'b1, 32'h0, 32'h20, 1'b0, 32'h100, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 32'h0, 1'b1, wordAt(32'h100), 32'h104, 1'b1, 32'h104, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 32'h200, 1'b1, wordAt(32'h100), 32'h104, 1'b1, 32'h104, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 32'h200, 1'b1, wordAt(32'h100), 32'h104, 1'b1, 32'h104, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 32'h200, 1'b1, 32'h0, 32'h104, 1'b0, 32'h200, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 32'h0, 1'b1, wordAt(32'h200), 32'h204, 1'b1, 32'h204, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h204, 1'b0, 32'h204, 1'b1};
        vecs[18] = '{1'b0, 1'b0, 32'h0, 1'b1, wordAt(32'h204), 32'h208, 1'b1, 32'h208, 1'b1};

        // Reset held for three cycles
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chkAll("reset", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        end
        rst = 1'b1;
        #1;
        chk("req_after_release", {31'd0, imem_req}, 32'd1);

        foreach (vecs[i]) begin
            drive(vecs[i].stall, vecs[i].jb, vecs[i].target, vecs[i].ready);
            step();
            chkAll($sformatf("vec%0d", i), vecs[i].expInstr, vecs[i].expPc4,
                   vecs[i].expValid, vecs[i].expPc, vecs[i].expReq);
        end

        // Wait states at the top of the address space, then wrap to zero
        drive(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        step();
        chkAll("wrapRedir", 32'h0, 32'h208, 1'b0, 32'hFFFF_FFFC, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        step();
        chkAll("wait1", 32'h0, 32'h208, 1'b0, 32'hFFFF_FFFC, 1'b1);
        step();
        chkAll("wait2", 32'h0, 32'h208, 1'b0, 32'hFFFF_FFFC, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        step();
        chkAll("wrap", wordAt(32'hFFFF_FFFC), 32'h0, 1'b1, 32'h0, 1'b1);
        step();
        chkAll("afterWrap", wordAt(32'h0), 32'h4, 1'b1, 32'h4, 1'b1);

        // Asynchronous reset while a word is parked
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        step();
        chkAll("enterHold", wordAt(32'h0), 32'h4, 1'b1, 32'h4, 1'b0);
        #3 rst = 1'b0;
        #1;
        chkAll("asyncReset", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        step();
        step();
        chkAll("resetHeld", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        step();
        chkAll("restart", wordAt(32'h0), 32'h4, 1'b1, 32'h4, 1'b1);

        // Randomized run against the reference model
        mPc = 32'h4; mInstr = wordAt(32'h0); mPc4 = 32'h4; mValid = 1'b1; mHeld = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic st, jb, rdy;
            logic [31:0] tgt;
            st  = ($urandom_range(0, 9) < 3);
            jb  = ($urandom_range(0, 9) < 2);
            rdy = ($urandom_range(0, 9) < 7);
            tgt = $urandom;
            junkWord = $urandom;
            drive(st, jb, tgt, rdy);
            step();
            if (jb && !st) begin
                mPc = {tgt[31:2], 2'b00};
                mInstr = 32'h0;
                mValid = 1'b0;
                mHeld = 1'b0;
            end else if (st) begin
                if (!mHeld && rdy) mHeld = 1'b1;
            end else if (mHeld || rdy) begin
                // The parked word was read at the current PC, which cannot move while parked.
                mInstr = wordAt(mPc);
                mPc4 = mPc + 32'd4;
                mValid = 1'b1;
                mPc = mPc + 32'd4;
                mHeld = 1'b0;
            end else begin
                mInstr = 32'h0;
                mValid = 1'b0;
            end
            chkAll("rand", mInstr, mPc4, mValid, mPc, !mHeld);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
